// File: rtl/soc_sram_port_arbiter_if.sv
// Bundles both requester ports and the SRAM controller port of the arbiter.
// The slave modport is the arbiter's view; master is the requester/controller side.
interface soc_sram_port_arbiter_if;
  logic        r0_req;
  logic [3:0]  r0_we;
  logic [19:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_lock;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;

  logic        r1_req;
  logic [3:0]  r1_we;
  logic [19:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_lock;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;

  logic        ctrl_ena;
  logic [3:0]  ctrl_wea;
  logic [19:0] ctrl_addra;
  logic [31:0] ctrl_dina;
  logic [31:0] ctrl_douta;
  logic        ctrl_readya;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    output r1_gnt, r1_rvalid, r1_rdata,
    output ctrl_ena, ctrl_wea, ctrl_addra, ctrl_dina,
    input  ctrl_douta, ctrl_readya
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_lock,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_lock,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  ctrl_ena, ctrl_wea, ctrl_addra, ctrl_dina,
    output ctrl_douta, ctrl_readya
  );
endinterface

// File: rtl/soc_sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between the AXI bridge (r0)
// and the boot/DMA loader (r1), with bounded lock bursts and tagged read return.
module soc_sram_port_arbiter #(
  parameter int unsigned LOCK_MAX = 8
) (
  input logic                    clk,
  input logic                    resetn,
  soc_sram_port_arbiter_if.slave bus
);

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN0 = 2'd1;
  localparam logic [1:0] ARB_OWN1 = 2'd2;
  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  logic [1:0] state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rvalid_q, rvalid_d;
  logic       rtag_q, rtag_d;

  logic       sel;
  logic       sel_req;
  logic       sel_lock;
  logic       other_req;
  logic       accept;
  logic       force_rel;
  logic [3:0] sel_we;
  logic [7:0] cnt_inc;

  // In an owned state only the owner is selectable; an idle owner selects nobody (r0 fields).
  always_comb begin
    sel     = 1'b0;
    sel_req = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        sel_req = bus.r0_req | bus.r1_req;
        sel     = (bus.r0_req & bus.r1_req) ? ptr_q : bus.r1_req;
      end
      ARB_OWN0: begin
        sel_req = bus.r0_req;
      end
      ARB_OWN1: begin
        sel     = bus.r1_req;
        sel_req = bus.r1_req;
      end
      default: ;
    endcase
  end

  assign accept    = sel_req & bus.ctrl_readya & resetn;
  assign sel_we    = sel ? bus.r1_we   : bus.r0_we;
  assign sel_lock  = sel ? bus.r1_lock : bus.r0_lock;
  assign other_req = sel ? bus.r0_req  : bus.r1_req;

  // Beat count including the beat being accepted; release once it reaches the limit with a waiter.
  assign cnt_inc   = (state_q == ARB_IDLE)   ? 8'd1  :
                     (cnt_q >= LOCK_LIMIT)   ? cnt_q : cnt_q + 8'd1;
  assign force_rel = other_req & (cnt_inc >= LOCK_LIMIT);

  always_comb begin
    state_d  = (state_q == 2'd3) ? ARB_IDLE : state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rtag_d   = rtag_q;
    if (accept) begin
      if (!sel_lock || force_rel) begin
        state_d = ARB_IDLE;
        ptr_d   = ~sel;
        cnt_d   = 8'd0;
      end else begin
        state_d = sel ? ARB_OWN1 : ARB_OWN0;
        cnt_d   = cnt_inc;
      end
      if (sel_we == 4'b0000) begin
        rvalid_d = 1'b1;
        rtag_d   = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= 8'd0;
      rvalid_q <= 1'b0;
      rtag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rtag_q   <= rtag_d;
    end
  end

  assign bus.ctrl_ena   = accept;
  assign bus.ctrl_wea   = sel_we;
  assign bus.ctrl_addra = sel ? bus.r1_addr  : bus.r0_addr;
  assign bus.ctrl_dina  = sel ? bus.r1_wdata : bus.r0_wdata;

  assign bus.r0_gnt    = accept & ~sel;
  assign bus.r1_gnt    = accept & sel;
  assign bus.r0_rvalid = rvalid_q & ~rtag_q & resetn;
  assign bus.r1_rvalid = rvalid_q & rtag_q & resetn;
  assign bus.r0_rdata  = bus.ctrl_douta;
  assign bus.r1_rdata  = bus.ctrl_douta;

endmodule

// File: tb/tb_soc_sram_port_arbiter.sv
// Directed bench for soc_sram_port_arbiter: expected grants and read returns are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_soc_sram_port_arbiter;

  typedef struct packed {
    logic        who;
    logic [3:0]  we;
    logic [19:0] addr;
    logic [31:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } rv_exp_t;

  logic clk;
  logic resetn;
  int   compare_count;
  int   mismatch_count;

  gnt_exp_t gnt_q[$];
  rv_exp_t  rv_q[$];
  logic [31:0] mem [0:255];
  logic prev_rd;
  logic prev_tag;

  soc_sram_port_arbiter_if bus ();

  soc_sram_port_arbiter #(.LOCK_MAX(4)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM controller: byte-enabled writes, read data one cycle after accept.
  always @(posedge clk) begin
    if (bus.ctrl_ena === 1'b1) begin
      if (bus.ctrl_wea != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (bus.ctrl_wea[b]) mem[bus.ctrl_addra[7:0]][8*b +: 8] <= bus.ctrl_dina[8*b +: 8];
      end else begin
        bus.ctrl_douta <= mem[bus.ctrl_addra[7:0]];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic r0q, input logic [3:0] r0we, input logic [19:0] r0a, input logic [31:0] r0d, input logic r0l,
    input logic r1q, input logic [3:0] r1we, input logic [19:0] r1a, input logic [31:0] r1d, input logic r1l,
    input logic rdy);
    bus.r0_req = r0q; bus.r0_we = r0we; bus.r0_addr = r0a; bus.r0_wdata = r0d; bus.r0_lock = r0l;
    bus.r1_req = r1q; bus.r1_we = r1we; bus.r1_addr = r1a; bus.r1_wdata = r1d; bus.r1_lock = r1l;
    bus.ctrl_readya = rdy;
  endtask

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 0, 4'h0, 20'h0, 32'h0, 0, 1);
    stepClock(n);
  endtask

  task automatic pushGnt(input logic who, input logic [3:0] we, input logic [19:0] addr, input logic [31:0] wdata);
    gnt_exp_t e;
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    gnt_q.push_back(e);
  endtask

  task automatic pushRv(input logic who, input logic [31:0] data);
    rv_exp_t e;
    e.who = who; e.data = data;
    rv_q.push_back(e);
  endtask

  // Holds reset for two cycles with both requesters asserting, checking outputs stay quiet.
  task automatic resetDut();
    resetn = 1'b0;
    applyStimulus(1, 4'h0, 20'h1, 32'h0, 1, 1, 4'h0, 20'h2, 32'h0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      #2;
      checkOutput("reset_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
      checkOutput("reset_ena", {31'd0, bus.ctrl_ena}, 32'd0);
      checkOutput("reset_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
      stepClock(1);
    end
    idleCycles(0);
    resetn = 1'b1;
    #2;
    checkOutput("post_reset_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    stepClock(1);
  endtask

  // Monitor: every grant and every read return must match the head of its queue.
  always @(negedge clk) begin
    gnt_exp_t g;
    rv_exp_t  r;
    if (resetn !== 1'b1) begin
      prev_rd  = 1'b0;
      prev_tag = 1'b0;
    end else begin
      if ((bus.r0_gnt | bus.r1_gnt) === 1'b1) begin
        checkOutput("gnt_onehot", {31'd0, bus.r0_gnt & bus.r1_gnt}, 32'd0);
        checkOutput("gnt_expected", {31'd0, gnt_q.size() != 0}, 32'd1);
        if (gnt_q.size() != 0) begin
          g = gnt_q.pop_front();
          checkOutput("gnt_who", {31'd0, bus.r1_gnt}, {31'd0, g.who});
          checkOutput("gnt_ena", {31'd0, bus.ctrl_ena}, 32'd1);
          checkOutput("gnt_addr", {12'd0, bus.ctrl_addra}, {12'd0, g.addr});
          checkOutput("gnt_we", {28'd0, bus.ctrl_wea}, {28'd0, g.we});
          if (g.we != 4'b0000) checkOutput("gnt_wdata", bus.ctrl_dina, g.wdata);
        end
      end
      if (prev_rd)
        checkOutput("rvalid_timing", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, prev_tag ? 32'd2 : 32'd1);
      else if ((bus.r0_rvalid | bus.r1_rvalid) === 1'b1)
        checkOutput("rvalid_spurious", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
      if ((bus.r0_rvalid | bus.r1_rvalid) === 1'b1) begin
        checkOutput("rvalid_expected", {31'd0, rv_q.size() != 0}, 32'd1);
        if (rv_q.size() != 0) begin
          r = rv_q.pop_front();
          checkOutput("rvalid_who", {31'd0, bus.r1_rvalid}, {31'd0, r.who});
          checkOutput("rdata", r.who ? bus.r1_rdata : bus.r0_rdata, r.data);
        end
      end
      prev_rd  = ((bus.r0_gnt | bus.r1_gnt) === 1'b1) && (bus.ctrl_wea == 4'b0000);
      prev_tag = bus.r1_gnt;
    end
  end

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    prev_rd        = 1'b0;
    prev_tag       = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    resetn = 1'b0;
    idleCycles(0);
    #1;

    $display("[TB] single requester write then read");
    resetDut();
    pushGnt(0, 4'hF, 20'h00010, 32'hDEADBEEF);
    pushGnt(0, 4'h0, 20'h00010, 32'h0);
    pushRv(0, 32'hDEADBEEF);
    applyStimulus(1, 4'hF, 20'h00010, 32'hDEADBEEF, 0, 0, 4'h0, 20'h0, 32'h0, 0, 1);
    stepClock(1);
    applyStimulus(1, 4'h0, 20'h00010, 32'h0, 0, 0, 4'h0, 20'h0, 32'h0, 0, 1);
    stepClock(1);
    idleCycles(2);

    $display("[TB] contention, round robin from r0");
    resetDut();
    for (int i = 0; i < 3; i++) begin
      pushGnt(0, 4'h0, 20'h00010, 32'h0);
      pushRv(0, 32'hDEADBEEF);
      pushGnt(1, 4'h0, 20'h00020, 32'h0);
      pushRv(1, 32'h1000_0020);
    end
    applyStimulus(1, 4'h0, 20'h00010, 32'h0, 0, 1, 4'h0, 20'h00020, 32'h0, 0, 1);
    stepClock(6);
    idleCycles(1);

    $display("[TB] r1 locked burst of three reads");
    for (int i = 0; i < 3; i++) begin
      pushGnt(1, 4'h0, 20'h00030 + 20'(i), 32'h0);
      pushRv(1, 32'h1000_0030 + i);
    end
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 1, 4'h0, 20'h00030, 32'h0, 1, 1);
    stepClock(1);
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 1, 4'h0, 20'h00031, 32'h0, 1, 1);
    stepClock(1);
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 1, 4'h0, 20'h00032, 32'h0, 0, 1);
    stepClock(1);
    pushGnt(0, 4'hF, 20'h00040, 32'h11111111);
    pushGnt(1, 4'h3, 20'h00041, 32'h22222222);
    applyStimulus(1, 4'hF, 20'h00040, 32'h11111111, 0, 1, 4'h3, 20'h00041, 32'h22222222, 0, 1);
    stepClock(2);
    idleCycles(2);

    $display("[TB] lock limit of four beats");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      pushGnt(0, 4'h0, 20'h00050, 32'h0);
      pushRv(0, 32'h1000_0050);
    end
    pushGnt(1, 4'h0, 20'h00060, 32'h0);
    pushRv(1, 32'h1000_0060);
    pushGnt(0, 4'h0, 20'h00050, 32'h0);
    pushRv(0, 32'h1000_0050);
    applyStimulus(1, 4'h0, 20'h00050, 32'h0, 1, 1, 4'h0, 20'h00060, 32'h0, 0, 1);
    stepClock(5);
    applyStimulus(1, 4'h0, 20'h00050, 32'h0, 1, 0, 4'h0, 20'h0, 32'h0, 0, 1);
    stepClock(1);
    idleCycles(2);

    $display("[TB] controller stall with both pending");
    resetDut();
    pushGnt(0, 4'h0, 20'h00070, 32'h0);
    pushRv(0, 32'h1000_0070);
    applyStimulus(1, 4'h0, 20'h00070, 32'h0, 0, 0, 4'h0, 20'h0, 32'h0, 0, 1);
    stepClock(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'h0, 20'h00070, 32'h0, 0, 1, 4'h0, 20'h00071, 32'h0, 0, 0);
      #2;
      checkOutput("stall_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
      checkOutput("stall_ena", {31'd0, bus.ctrl_ena}, 32'd0);
      stepClock(1);
    end
    pushGnt(1, 4'h0, 20'h00071, 32'h0);
    pushRv(1, 32'h1000_0071);
    pushGnt(0, 4'h0, 20'h00070, 32'h0);
    pushRv(0, 32'h1000_0070);
    applyStimulus(1, 4'h0, 20'h00070, 32'h0, 0, 1, 4'h0, 20'h00071, 32'h0, 0, 1);
    stepClock(2);
    idleCycles(2);

    $display("[TB] reset during r1 lock burst");
    pushGnt(1, 4'h0, 20'h00090, 32'h0);
    pushRv(1, 32'h1000_0090);
    pushGnt(1, 4'h0, 20'h00091, 32'h0);
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 1, 4'h0, 20'h00090, 32'h0, 1, 1);
    stepClock(1);
    applyStimulus(0, 4'h0, 20'h0, 32'h0, 0, 1, 4'h0, 20'h00091, 32'h0, 1, 1);
    stepClock(1);
    resetn = 1'b0;
    applyStimulus(1, 4'h0, 20'h00080, 32'h0, 0, 1, 4'h0, 20'h00092, 32'h0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      #2;
      checkOutput("midlock_reset_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
      checkOutput("midlock_reset_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
      stepClock(1);
    end
    pushGnt(0, 4'h0, 20'h00080, 32'h0);
    pushRv(0, 32'h1000_0080);
    resetn = 1'b1;
    applyStimulus(1, 4'h0, 20'h00080, 32'h0, 0, 1, 4'h0, 20'h00092, 32'h0, 0, 1);
    #2;
    checkOutput("midlock_release_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    stepClock(1);
    idleCycles(3);

    checkOutput("gnt_queue_drained", gnt_q.size(), 32'd0);
    checkOutput("rv_queue_drained", rv_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/soc_sram_port_arbiter.md
Name: soc_sram_port_arbiter

Overview:
- Shares the single-access port of the SRAM controller (ena/wea/addra/dina/douta/readya) between two requesters.
- r0 is the AXI-to-SRAM bridge; r1 is the boot/DMA loader.
- Round-robin arbitration, with an optional per-requester lock for back-to-back beats and a bounded lock length.
- Returns read data to the requester that issued the read, one cycle after the access is accepted.

Parameters:
- LOCK_MAX, 8, max consecutive accepted beats for one locked owner while the other requester is waiting (1..255).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- r0_req  in  1  r0 access request; fields below must be stable while r0_req=1 and r0_gnt=0
- r0_we  in  4  r0 byte write enables; 0000 = read
- r0_addr  in  20  r0 word address
- r0_wdata  in  32  r0 write data
- r0_lock  in  1  r0 keeps ownership after this beat
- r0_gnt  out  1  r0 beat accepted this cycle (combinational)
- r0_rvalid  out  1  r0 read data valid
- r0_rdata  out  32  r0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_lock, r1_gnt, r1_rvalid, r1_rdata  (same as r0, for r1)
- ctrl_ena  out  1  controller access enable
- ctrl_wea  out  4  controller byte write enables
- ctrl_addra  out  20  controller word address
- ctrl_dina  out  32  controller write data
- ctrl_douta  in  32  controller read data, valid the cycle after an accepted read
- ctrl_readya  in  1  controller can accept an access this cycle

Behaviour:
- Reset (resetn=0 at posedge): state=ARB_IDLE, priority pointer=r0, lock count=0, rvalid/rtag registers=0.
- Outputs during and right after reset: rX_gnt=0 and ctrl_ena=0 while resetn=0; rX_rvalid=0 in the cycle after reset.
- Accept: ctrl_ena = selected requester's req & ctrl_readya. rX_gnt=1 only for the selected requester, and only when ctrl_ena=1. At most one gnt per cycle.
- Forwarding: ctrl_wea, ctrl_addra and ctrl_dina always carry the selected requester's fields (r0's when nobody is selected).
- ARB_IDLE:
  - Selection: one requester -> it is selected; both -> the priority pointer picks.
  - On accept with lock=0: stay in ARB_IDLE; pointer moves to the non-granted requester.
  - On accept with lock=1: go to ARB_OWNx (x = granted requester); lock count=1.
- ARB_OWNx: only rx is selectable; the other requester waits and its gnt stays 0.
  - Accept with rx_lock=0 -> ARB_IDLE; pointer = other requester; count cleared.
  - Accept with rx_lock=1 -> count+1.
  - Forced release: count==LOCK_MAX, the other req=1 and an accept occurs -> ARB_IDLE, pointer = other requester, regardless of rx_lock.
  - Owner has rx_req=0: stay in ARB_OWNx, no access, count held.
  - Count saturates at LOCK_MAX while the other requester is idle.
- Read return: on an accept with we==0000, register rtag=x and rpend=1. Next cycle: rx_rvalid=1 and rx_rdata=ctrl_douta. No backpressure; the other requester's rvalid stays 0.
- Write accepts produce no rvalid.
- rX_rdata is driven from ctrl_douta at all times; it is meaningful only while rX_rvalid=1.
- Reads may be accepted every cycle, giving back-to-back rvalids. Alternating owners give correctly tagged returns.
- ctrl_readya=0: no gnt, ctrl_ena=0, state/pointer/count held.
- Reset mid-lock: the next cycle is ARB_IDLE with pointer=r0; any pending rvalid is dropped.

Test Plan:
- Single requester: r0 writes we=1111 addr=0x00010 wdata=0xDEADBEEF, then reads addr=0x00010 -> ctrl_ena one cycle each; r0_rvalid=1 one cycle after the read gnt with r0_rdata=ctrl_douta=0xDEADBEEF; r1_rvalid=0 throughout.
- Contention: r0 and r1 request continuously, lock=0, readya=1 -> grants alternate r0,r1,r0,r1 starting with r0 after reset; never two gnts in one cycle.
- Lock: r1 locked for 3 reads while r0 idle -> 3 consecutive r1_gnt; r1_rvalid on 3 consecutive cycles, each one cycle after its gnt; return to ARB_IDLE after the beat with lock=0.
- Lock limit: LOCK_MAX=4, r0 locks permanently, r1_req=1 -> exactly 4 r0 gnts, then r1_gnt, then r0 regains.
- Stall: ctrl_readya=0 for 5 cycles with both requests pending -> no gnt, ctrl_ena=0, pointer unchanged; the first gnt after readya rises goes to the pointer's requester.
- Reset mid-lock: assert resetn=0 during an ARB_OWN1 burst -> all gnt/rvalid=0; after release r0 wins a simultaneous request.
